// File: rtl/gen_regs_mp_pkg.sv
// Shared sizing helpers for the multi-port register file.
package gen_regs_pkg;

   function automatic int aw_f(input int nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

   function automatic int nbytes_f(input int xlen);
      return xlen / 8;
   endfunction

endpackage

// File: rtl/gen_regs_mp_if.sv
// Read/write/issue bundle of the multi-port register file; the pipeline is master.
interface gen_regs_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) ();
   import gen_regs_pkg::*;

   localparam int AW = aw_f(NREGS);
   localparam int NB = nbytes_f(XLEN);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR*NB-1:0]   wr_be;
   logic [NWR-1:0]      wr_clr;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, wr_be, wr_clr, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, wr_be, wr_clr, iss_en, iss_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/gen_regs_mp_wmerge.sv
// Byte-wise merge of all write ports hitting one address; later ports override earlier ones.
module gen_regs_mp_wmerge
   import gen_regs_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NWR  = 2
) (
   input  logic [AW-1:0]              addr_i,
   input  logic [XLEN-1:0]            old_i,
   input  logic [NWR-1:0]             wr_en_i,
   input  logic [NWR*AW-1:0]          wr_addr_i,
   input  logic [NWR*XLEN-1:0]        wr_data_i,
   input  logic [NWR*(XLEN/8)-1:0]    wr_be_i,
   output logic [XLEN-1:0]            data_o,
   output logic                       hit_o
);
   localparam int NB = nbytes_f(XLEN);

   always_comb begin
      data_o = old_i;
      hit_o  = 1'b0;
      // ascending scan so the highest-index enabled port owns each byte
      for (int p = 0; p < NWR; p++) begin
         if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == addr_i)) begin
            hit_o = 1'b1;
            for (int b = 0; b < NB; b++) begin
               if (wr_be_i[p*NB + b])
                  data_o[b*8 +: 8] = wr_data_i[p*XLEN + b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/gen_regs_mp.sv
// Multi-port register file with byte-enable writes, optional read bypass and busy scoreboard.
module gen_regs_mp
   import gen_regs_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          reset,
   gen_regs_mp_if.slave  bus
);
   localparam int AW = aw_f(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs_q;
   logic [XLEN-1:0]            regs_d [NREGS];
   logic                       wr_hit [NREGS];
   logic [NREGS-1:0]           busy_q, busy_d;
   logic [NRD-1:0][XLEN-1:0]   rd_data;
   logic [NRD-1:0]             rd_busy;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      if (ZERO_REG != 0 && r == 0) begin : g_zero
         assign regs_d[r] = '0;
         assign wr_hit[r] = 1'b0;
      end else begin : g_wr
         gen_regs_mp_wmerge #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wm (
            .addr_i    (AW'(r)),
            .old_i     (regs_q[r]),
            .wr_en_i   (bus.wr_en),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .wr_be_i   (bus.wr_be),
            .data_o    (regs_d[r]),
            .hit_o     (wr_hit[r])
         );
      end
   end

   // issue is applied after retire so a same-cycle set overrides the clear
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NWR; p++) begin
         if (bus.wr_en[p] && bus.wr_clr[p])
            busy_d[bus.wr_addr[p*AW +: AW]] = 1'b0;
      end
      if (bus.iss_en)
         busy_d[bus.iss_addr] = 1'b1;
      if (ZERO_REG != 0)
         busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_hit[r])
               regs_q[r] <= regs_d[r];
         end
         busy_q <= busy_d;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] byp_data;
      logic            byp_hit;

      assign ra = bus.rd_addr[p*AW +: AW];

      gen_regs_mp_wmerge #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
         .addr_i    (ra),
         .old_i     (regs_q[ra]),
         .wr_en_i   (bus.wr_en),
         .wr_addr_i (bus.wr_addr),
         .wr_data_i (bus.wr_data),
         .wr_be_i   (bus.wr_be),
         .data_o    (byp_data),
         .hit_o     (byp_hit)
      );

      assign rd_data[p] = (ZERO_REG != 0 && ra == '0)  ? '0 :
                          (BYPASS != 0 && byp_hit)     ? byp_data :
                                                         regs_q[ra];
      assign rd_busy[p] = busy_q[ra];
   end

   assign bus.rd_data  = rd_data;
   assign bus.rd_busy  = rd_busy;
   assign bus.busy_vec = busy_q;

endmodule
